agc_datapath: RTL and testbench
===============================

AGC_DATAPATH -- requirements
Module: agc_datapath

Interface
REQ-001 SHALL have ports clk, input, 1, sole clock (all state updates on rising edge).
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have control inputs ext_flag, mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr, y_wr, x_wr, z_wr, maddr_mux, mdata_mux, lp_mux, g_mux, b_mux, each 1 bit, from the control-pulse sequencer.
REQ-004 SHALL have inputs q_mux, a_mux, x_mux, z_mux, each 2 bits, and alu_op and y_mux, each 3 bits.
REQ-005 SHALL have memory ports mem_addr (out, 12), mem_wdata (out, 16), mem_we (out, 1), and mem_rdata (in, 16, combinational read of mem_addr, same cycle).
REQ-006 SHALL have decode outputs opcode (out, 3) = B[14:12], qc (out, 2) = B[11:10], extracode (out, 1), and ovf (out, 1, sticky add/sub overflow).

Function
REQ-007 SHALL hold 16-bit registers A, L, G, Q, B, X, Y and a 12-bit register Z (program counter); each SHALL load only when its *_wr is 1 at a rising edge.
REQ-008 SHALL compute every same-cycle write from pre-edge register values, so simultaneous writes (for example g_wr with a_wr) SHALL NOT observe each other.
REQ-009 SHALL drive mem_addr = Z when maddr_mux=0 and B[11:0] when maddr_mux=1.
REQ-010 SHALL drive mem_wdata = A when mdata_mux=0 and L when mdata_mux=1, and SHALL drive mem_we = mem_wr.
REQ-011 SHALL select b_mux as 0 = mem_rdata, 1 = alu_out.
REQ-012 SHALL select g_mux as 0 = mem_rdata, 1 = A.
REQ-013 SHALL select lp_mux as 0 = A, 1 = alu_out.
REQ-014 SHALL select a_mux as 0 = mem_rdata, 1 = alu_out, 2 = bitwise ~A, 3 = G.
REQ-015 SHALL select q_mux as 0 = A, 1 = alu_out, 2 = zero-extended Z, 3 = 0.
REQ-016 SHALL select z_mux as 0 = A[11:0], 1 = alu_out[11:0], 2 = B[11:0], 3 = Q[11:0].
REQ-017 SHALL select x_mux as 0 = mem_rdata, 1 = zero-extended Z, 2 = B, 3 = A.
REQ-018 SHALL select y_mux as 0 = 0, 1 = A, 2 = 16'd1, 3 = G, 4 = L, and 5..7 = 0.
REQ-019 SHALL compute alu_out combinationally from X and Y:
  - 0 AD = X+Y
  - 1 SU = Y−X
  - 2 MASK = X&Y
  - 3 MP0 = low 16 bits of the signed product X*Y
  - 4 MP1 = high 16 bits of that product
  - 5 DV0 = signed remainder Y%X
  - 6 DV1 = signed quotient Y/X
  - 7 = 0
REQ-020 SHALL, on divide-by-zero (X=0), produce DV1 = 16'hFFFF and DV0 = Y.
REQ-021 SHALL use two's-complement arithmetic, truncated to 16 bits.
REQ-022 SHALL set ovf to 1 at an edge where a_wr=1, a_mux=1, alu_op is AD or SU, and signed overflow occurs; ovf SHALL then stay 1 until reset.
REQ-023 SHALL register extracode <= ext_flag every cycle, giving a one-cycle latency.
REQ-024 SHALL let Z wrap from 12'hFFF to 12'h000 through the truncation in the z_mux=1 path.

Reset
REQ-025 SHALL, when rst=1 at an edge, clear A, L, G, Q, B, X, Y, Z, extracode, and ovf to 0, overriding all *_wr inputs.
REQ-026 SHALL, when reset is asserted mid-instruction, discard all pending writes in that cycle; mem_we SHALL still equal mem_wr combinationally, because memory gating is the sequencer's responsibility.
REQ-027 SHALL, in the first cycle after reset, present opcode=0, qc=0, and mem_addr=0 when maddr_mux=0.

Configuration
REQ-028 SHALL compile the divider in for alu_op 5/6 when macro AGC_DATAPATH_DV_EN is defined; without the macro, alu_op 5 and 6 SHALL yield alu_out=0 and no divider logic SHALL be present.

Verification
REQ-029 SHALL cover fetch: Z=12'h010, mem[0x010]=16'h6123, maddr_mux=0, b_mux=0, b_wr=1 -> B=16'h6123, opcode=6, qc=0.
REQ-030 SHALL cover PC increment: x_mux=1, y_mux=2, alu_op=0 then z_mux=1, z_wr=1, with Z=12'hFFF -> Z=12'h000.
REQ-031 SHALL cover XCH swap: A=16'h1111, mem[B]=16'h2222; edge 1 g_wr (mem_rdata); edge 2 mem_wr, mdata_mux=0; edge 3 a_mux=3 -> mem[B]=16'h1111, A=16'h2222.
REQ-032 SHALL cover overflow: X=16'h7FFF, Y=16'h0001, AD into A -> A=16'h8000, ovf=1; ovf SHALL stay 1 until rst.
REQ-033 SHALL cover MP: X=16'h0100, Y=16'h0300, MP0 to L, MP1 to A -> L=16'h0000, A=16'h0003.
REQ-034 SHALL cover DV with AGC_DATAPATH_DV_EN defined: Y=16'd100, X=16'd7 -> DV1=16'd14, DV0=16'd2; with X=0 -> 16'hFFFF and 16'd100; with rst mid-sequence -> all registers 0 next cycle.

Source files
------------

// File: rtl/agc_datapath.sv
// AGC-style register/ALU datapath driven by a control-pulse sequencer.
// Optional divider for alu_op 5/6 is built only with AGC_DATAPATH_DV_EN.
module agc_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_flag,
    input  logic        mem_wr,
    input  logic        lp_wr,
    input  logic        g_wr,
    input  logic        q_wr,
    input  logic        b_wr,
    input  logic        a_wr,
    input  logic        y_wr,
    input  logic        x_wr,
    input  logic        z_wr,
    input  logic        maddr_mux,
    input  logic        mdata_mux,
    input  logic        lp_mux,
    input  logic        g_mux,
    input  logic        b_mux,
    input  logic [1:0]  q_mux,
    input  logic [1:0]  a_mux,
    input  logic [1:0]  x_mux,
    input  logic [1:0]  z_mux,
    input  logic [2:0]  alu_op,
    input  logic [2:0]  y_mux,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  opcode,
    output logic [1:0]  qc,
    output logic        extracode,
    output logic        ovf
);

    logic [15:0] r_a, r_l, r_g, r_q, r_b, r_x, r_y;
    logic [11:0] r_z;
    logic        r_ext, r_ovf;

    logic [15:0]        w_alu, w_add, w_sub;
    logic signed [31:0] w_prod;
    logic [15:0]        w_quo, w_rem;
    logic [15:0]        w_a_nx, w_q_nx, w_x_nx, w_y_nx;
    logic [11:0]        w_z_nx;
    logic               w_ovf_hit;
    logic               w_unused;

    assign w_add  = r_x + r_y;
    assign w_sub  = r_y - r_x;
    assign w_prod = $signed(r_x) * $signed(r_y);

`ifdef AGC_DATAPATH_DV_EN
    // Divide-by-zero returns all-ones quotient and passes the dividend through
    always_comb begin
        w_quo = 16'hFFFF;
        w_rem = r_y;
        if (r_x != 16'd0) begin
            w_quo = 16'($signed(r_y) / $signed(r_x));
            w_rem = 16'($signed(r_y) % $signed(r_x));
        end
    end
`else
    assign w_quo = 16'd0;
    assign w_rem = 16'd0;
`endif

    always_comb begin
        w_alu = 16'd0;
        case (alu_op)
            3'd0: w_alu = w_add;
            3'd1: w_alu = w_sub;
            3'd2: w_alu = r_x & r_y;
            3'd3: w_alu = w_prod[15:0];
            3'd4: w_alu = w_prod[31:16];
            3'd5: w_alu = w_rem;
            3'd6: w_alu = w_quo;
            default: w_alu = 16'd0;
        endcase
    end

    always_comb begin
        w_ovf_hit = 1'b0;
        if (a_wr && a_mux == 2'd1) begin
            if (alu_op == 3'd0)
                w_ovf_hit = (r_x[15] == r_y[15]) && (w_add[15] != r_x[15]);
            else if (alu_op == 3'd1)
                w_ovf_hit = (r_x[15] != r_y[15]) && (w_sub[15] != r_y[15]);
        end
    end

    always_comb begin
        w_a_nx = 16'd0;
        w_q_nx = 16'd0;
        w_x_nx = 16'd0;
        w_y_nx = 16'd0;
        w_z_nx = 12'd0;
        case (a_mux)
            2'd0: w_a_nx = mem_rdata;
            2'd1: w_a_nx = w_alu;
            2'd2: w_a_nx = ~r_a;
            default: w_a_nx = r_g;
        endcase
        case (q_mux)
            2'd0: w_q_nx = r_a;
            2'd1: w_q_nx = w_alu;
            2'd2: w_q_nx = {4'd0, r_z};
            default: w_q_nx = 16'd0;
        endcase
        case (z_mux)
            2'd0: w_z_nx = r_a[11:0];
            2'd1: w_z_nx = w_alu[11:0];
            2'd2: w_z_nx = r_b[11:0];
            default: w_z_nx = r_q[11:0];
        endcase
        case (x_mux)
            2'd0: w_x_nx = mem_rdata;
            2'd1: w_x_nx = {4'd0, r_z};
            2'd2: w_x_nx = r_b;
            default: w_x_nx = r_a;
        endcase
        case (y_mux)
            3'd1: w_y_nx = r_a;
            3'd2: w_y_nx = 16'd1;
            3'd3: w_y_nx = r_g;
            3'd4: w_y_nx = r_l;
            default: w_y_nx = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= 16'd0;
            r_l   <= 16'd0;
            r_g   <= 16'd0;
            r_q   <= 16'd0;
            r_b   <= 16'd0;
            r_x   <= 16'd0;
            r_y   <= 16'd0;
            r_z   <= 12'd0;
            r_ext <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_ext <= ext_flag;
            if (w_ovf_hit) r_ovf <= 1'b1;
            if (a_wr)  r_a <= w_a_nx;
            if (lp_wr) r_l <= lp_mux ? w_alu : r_a;
            if (g_wr)  r_g <= g_mux ? r_a : mem_rdata;
            if (q_wr)  r_q <= w_q_nx;
            if (b_wr)  r_b <= b_mux ? w_alu : mem_rdata;
            if (x_wr)  r_x <= w_x_nx;
            if (y_wr)  r_y <= w_y_nx;
            if (z_wr)  r_z <= w_z_nx;
        end
    end

    assign mem_addr  = maddr_mux ? r_b[11:0] : r_z;
    assign mem_wdata = mdata_mux ? r_l : r_a;
    assign mem_we    = mem_wr;
    assign opcode    = r_b[14:12];
    assign qc        = r_b[11:10];
    assign extracode = r_ext;
    assign ovf       = r_ovf;
    assign w_unused  = ^r_q[15:12];

endmodule

// File: tb/tb_agc_datapath.sv
// Directed scoreboard bench for agc_datapath with a behavioural memory.
// Divider results depend on AGC_DATAPATH_DV_EN being defined.
module tb_agc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_flag, mem_wr, lp_wr, g_wr, q_wr, b_wr, a_wr;
    logic        y_wr, x_wr, z_wr;
    logic        maddr_mux, mdata_mux, lp_mux, g_mux, b_mux;
    logic [1:0]  q_mux, a_mux, x_mux, z_mux;
    logic [2:0]  alu_op, y_mux;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_we;
    logic [2:0]  opcode;
    logic [1:0]  qc;
    logic        extracode, ovf;

    logic [15:0] mem [0:4095];

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sbq[$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    agc_datapath dut (
        .clk(clk), .rst(rst), .ext_flag(ext_flag),
        .mem_wr(mem_wr), .lp_wr(lp_wr), .g_wr(g_wr),
        .q_wr(q_wr), .b_wr(b_wr), .a_wr(a_wr),
        .y_wr(y_wr), .x_wr(x_wr), .z_wr(z_wr),
        .maddr_mux(maddr_mux), .mdata_mux(mdata_mux),
        .lp_mux(lp_mux), .g_mux(g_mux), .b_mux(b_mux),
        .q_mux(q_mux), .a_mux(a_mux), .x_mux(x_mux),
        .z_mux(z_mux), .alu_op(alu_op), .y_mux(y_mux),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata),
        .opcode(opcode), .qc(qc),
        .extracode(extracode), .ovf(ovf)
    );

    task automatic idle();
        ext_flag = 0; mem_wr = 0; lp_wr = 0; g_wr = 0;
        q_wr = 0; b_wr = 0; a_wr = 0; y_wr = 0;
        x_wr = 0; z_wr = 0; maddr_mux = 0; mdata_mux = 0;
        lp_mux = 0; g_mux = 0; b_mux = 0; q_mux = 0;
        a_mux = 0; x_mux = 0; z_mux = 0; alu_op = 0; y_mux = 0;
    endtask

    // Memory write is captured with the pre-edge address/data
    task automatic step();
        logic        we;
        logic [11:0] wa;
        logic [15:0] wd;
        we = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        if (we) mem[wa] = wd;
        #1;
        idle();
        #1;
    endtask

    task automatic push(input string t, input logic [15:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        n_total++;
        if (sbq.size() == 0) begin
            $error("FAIL scoreboard_empty got %h want <entry>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s got %h want %h", e.tag, obs, e.val);
        end
    endtask

    task automatic see_a(input string t, input logic [15:0] v);
        push(t, v);
        mdata_mux = 0; #1;
        chk(mem_wdata);
        mdata_mux = 0;
    endtask

    task automatic see_l(input string t, input logic [15:0] v);
        push(t, v);
        mdata_mux = 1; #1;
        chk(mem_wdata);
        mdata_mux = 0;
    endtask

    task automatic see_z(input string t, input logic [11:0] v);
        push(t, {4'd0, v});
        maddr_mux = 0; #1;
        chk({4'd0, mem_addr});
    endtask

    task automatic see_b(input string t, input logic [15:0] v);
        push({t, "_op"}, {13'd0, v[14:12]});
        chk({13'd0, opcode});
        push({t, "_qc"}, {14'd0, v[11:10]});
        chk({14'd0, qc});
        push({t, "_addr"}, {4'd0, v[11:0]});
        maddr_mux = 1; #1;
        chk({4'd0, mem_addr});
        maddr_mux = 0; #1;
    endtask

    task automatic load_a(input logic [15:0] v);
        mem[mem_addr] = v;
        a_mux = 0; a_wr = 1;
        step();
    endtask

    task automatic load_x(input logic [15:0] v);
        mem[mem_addr] = v;
        x_mux = 0; x_wr = 1;
        step();
    endtask

    task automatic load_y(input logic [15:0] v);
        load_a(v);
        y_mux = 1; y_wr = 1;
        step();
    endtask

    task automatic set_z(input logic [11:0] v);
        load_a({4'd0, v});
        z_mux = 0; z_wr = 1;
        step();
    endtask

    task automatic alu_to_a(input logic [2:0] op);
        alu_op = op; a_mux = 1; a_wr = 1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'd0;
        idle();
        rst = 1;
        step();
        step();
        rst = 0;

        // Reset state
        see_a("rst_a", 16'h0000);
        see_l("rst_l", 16'h0000);
        see_z("rst_z", 12'h000);
        see_b("rst_b", 16'h0000);
        push("rst_ovf", 16'd0); chk({15'd0, ovf});
        push("rst_ext", 16'd0); chk({15'd0, extracode});
        load_a(16'h0005);
        a_mux = 3; a_wr = 1; step();
        see_a("rst_g", 16'h0000);

        // Fetch
        set_z(12'h010);
        see_z("fetch_z", 12'h010);
        mem[12'h010] = 16'h6123;
        b_mux = 0; b_wr = 1; step();
        see_b("fetch_b", 16'h6123);

        // PC increment wraps
        set_z(12'hFFF);
        x_mux = 1; x_wr = 1; y_mux = 2; y_wr = 1; step();
        alu_op = 0; z_mux = 1; z_wr = 1; step();
        see_z("pc_wrap", 12'h000);

        // XCH
        mem[12'h123] = 16'h2222;
        load_a(16'h1111);
        maddr_mux = 1; g_mux = 0; g_wr = 1; step();
        maddr_mux = 1; mem_wr = 1; mdata_mux = 0;
        push("memwe_comb", 16'd1); #1; chk({15'd0, mem_we});
        step();
        a_mux = 3; a_wr = 1; step();
        push("xch_mem", 16'h1111); chk(mem[12'h123]);
        see_a("xch_a", 16'h2222);

        // Same-edge writes see pre-edge values
        g_mux = 1; g_wr = 1; a_mux = 2; a_wr = 1; step();
        see_a("sim_nota", 16'hDDDD);
        a_mux = 3; a_wr = 1; step();
        see_a("sim_g", 16'h2222);

        // ALU result into B, then B and G as operands
        load_y(16'h2005);
        load_x(16'h1000);
        alu_op = 0; b_mux = 1; b_wr = 1; step();
        see_b("b_alu", 16'h3005);
        x_mux = 2; x_wr = 1; y_mux = 3; y_wr = 1; step();
        alu_to_a(3'd0);
        see_a("xb_yg", 16'h5227);

        // Overflow sticky
        push("ovf_pre", 16'd0); chk({15'd0, ovf});
        load_y(16'h0001);
        load_x(16'h7FFF);
        alu_to_a(3'd0);
        see_a("ovf_sum", 16'h8000);
        push("ovf_set", 16'd1); chk({15'd0, ovf});
        load_x(16'h0000);
        alu_to_a(3'd0);
        see_a("ovf_add2", 16'h0001);
        push("ovf_hold", 16'd1); chk({15'd0, ovf});

        // SU and MASK
        load_y(16'h0003);
        load_x(16'h0005);
        alu_to_a(3'd1);
        see_a("su", 16'hFFFE);
        load_y(16'h0F0F);
        load_x(16'h33CC);
        alu_to_a(3'd2);
        see_a("mask", 16'h030C);
        alu_to_a(3'd7);
        see_a("op7", 16'h0000);

        // MP
        load_y(16'h0300);
        lp_mux = 0; lp_wr = 1; step();
        see_l("l_from_a", 16'h0300);
        load_x(16'h0100);
        alu_op = 3; lp_mux = 1; lp_wr = 1; step();
        alu_to_a(3'd4);
        see_l("mp0", 16'h0000);
        see_a("mp1", 16'h0003);
        load_y(16'h0003);
        load_x(16'hFFFE);
        alu_to_a(3'd3);
        see_a("mp0_neg", 16'hFFFA);
        alu_to_a(3'd4);
        see_a("mp1_neg", 16'hFFFF);

        // X from A, Y from L
        load_a(16'h0010);
        lp_mux = 0; lp_wr = 1; step();
        load_a(16'h0005);
        x_mux = 3; x_wr = 1; y_mux = 4; y_wr = 1; step();
        alu_to_a(3'd0);
        see_a("xa_yl", 16'h0015);

        // DV
        load_y(16'd100);
        load_x(16'd7);
`ifdef AGC_DATAPATH_DV_EN
        alu_to_a(3'd6); see_a("dv1", 16'd14);
        alu_to_a(3'd5); see_a("dv0", 16'd2);
        load_x(16'd0);
        alu_to_a(3'd6); see_a("dv1_z", 16'hFFFF);
        alu_to_a(3'd5); see_a("dv0_z", 16'd100);
        load_y(16'hFFF9);
        load_x(16'd2);
        alu_to_a(3'd6); see_a("dv1_neg", 16'hFFFD);
        alu_to_a(3'd5); see_a("dv0_neg", 16'hFFFF);
`else
        alu_to_a(3'd6); see_a("dv1_off", 16'd0);
        load_a(16'h00AA);
        alu_to_a(3'd5); see_a("dv0_off", 16'd0);
`endif

        // Q path via Z
        set_z(12'h0AB);
        q_mux = 2; q_wr = 1; step();
        set_z(12'h321);
        z_mux = 3; z_wr = 1; step();
        see_z("z_from_q", 12'h0AB);
        q_mux = 3; q_wr = 1; step();
        z_mux = 3; z_wr = 1; step();
        see_z("q_zero", 12'h000);

        // extracode latency
        ext_flag = 1; #1;
        push("ext_pre", 16'd0); chk({15'd0, extracode});
        ext_flag = 1; step();
        push("ext_post", 16'd1); chk({15'd0, extracode});
        step();
        push("ext_clr", 16'd0); chk({15'd0, extracode});

        // Reset mid-instruction discards writes
        set_z(12'h055);
        load_a(16'h1234);
        mem[12'h055] = 16'h7777;
        a_mux = 2; a_wr = 1; lp_mux = 0; lp_wr = 1;
        z_mux = 0; z_wr = 1; b_mux = 0; b_wr = 1;
        mem_wr = 1; ext_flag = 1; rst = 1; #1;
        push("rst_memwe", 16'd1); chk({15'd0, mem_we});
        step();
        rst = 0;
        see_a("mid_a", 16'h0000);
        see_l("mid_l", 16'h0000);
        see_z("mid_z", 12'h000);
        see_b("mid_b", 16'h0000);
        push("mid_ovf", 16'd0); chk({15'd0, ovf});
        push("mid_ext", 16'd0); chk({15'd0, extracode});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
